huffman_encoder: RTL and testbench
==================================

# huffman_encoder

Huffman encoder: accepts 8-bit symbols on a valid/ready handshake and emits their prefix-free codes MSB-first as a stream of 2-bit digits. Each digit carries a valid flag and a last-digit marker, so the output stream is the direct input format of the team's 2-bit-per-cycle Huffman decoder. Sits upstream of the decoder/channel; a codebook lookup feeds a shift-register serializer with downstream backpressure.

## Interface
- `MAX_DIGITS`, default 5: capacity of the code shift register, in 2-bit digits. Must be ≥5 when escape is enabled, else ≥3.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-low reset (asserted when 0).
- `sym_in` input 8: symbol to encode.
- `sym_valid` input 1: `sym_in` valid.
- `sym_ready` output 1: encoder can accept a symbol this cycle.
- `bit_out` output 2: current code digit, MSB-first within the code.
- `valid_out` output 1: `bit_out` valid.
- `ready_out` input 1: downstream accepts `bit_out` this cycle.
- `last_out` output 1: the current digit is the final digit of its code.
- `err_out` output 1: one-cycle pulse when an unmapped symbol is rejected.

## Operation
- Codebook, digits listed MSB-first, prefix-free over 2-bit digits:
  - `0x41` 'A' = 00,00
  - `0x42` 'B` = 00,01
  - `0x43` 'C' = 00,10,00
  - `0x44` 'D' = 01,00
  - `0x45` 'E' = 10,00
- Digit 11 in first position is reserved for escape.
- Handshake: a symbol transfers when `sym_valid && sym_ready`; a digit transfers when `valid_out && ready_out`. `valid_out`, `bit_out` and `last_out` stay stable until the digit transfers.
- FSM states:
  - IDLE: `sym_ready`=1, `valid_out`=0. On a mapped transfer, load the code and its digit count, go to SHIFT. On an unmapped transfer, pulse `err_out` and stay in IDLE.
  - SHIFT: `valid_out`=1. On each digit transfer, shift left one digit and decrement the remaining count. `last_out`=1 when remaining count is 1.
- Back-to-back: in SHIFT, `sym_ready = last_out && ready_out`. A symbol accepted together with the last-digit transfer reloads the shift register directly, with no idle cycle. If that back-to-back symbol is unmapped, pulse `err_out` and go to IDLE.
- Remaining-count register is `$clog2(MAX_DIGITS+1)` bits wide; it never underflows.
- Reset (`reset`=0 at a clock edge): drop any code in progress with no partial completion. All outputs read 0 the next cycle: `sym_ready`=0, `valid_out`=0, `bit_out`=00, `last_out`=0, `err_out`=0. State goes to IDLE; `sym_ready` rises to 1 the cycle after reset deasserts.

## Timing
- Symbol accepted at edge N: first digit is valid from cycle N+1. All outputs are registered except `sym_ready`, which is combinational from state, count and `ready_out`.
- Throughput without stalls is one digit per cycle. A k-digit code occupies exactly k cycles.
- `err_out` is high for exactly the one cycle after the rejected transfer.
- With `ready_out` held low, the current digit holds indefinitely and `sym_ready`=0.

## Configuration
- `HUFFMAN_ENC_ESCAPE_EN` defined: an unmapped symbol is encoded as five digits: 11, then `sym_in[7:6]`, `[5:4]`, `[3:2]`, `[1:0]`. `err_out` is tied 0.
- `HUFFMAN_ENC_ESCAPE_EN` undefined: an unmapped symbol is dropped and `err_out` pulses.

## Structure
- Package `huffman_pkg` holds:
  - `code_entry_t`, a struct with `logic [2*MAX_DIGITS-1:0] bits` (MSB-aligned) and a digit-count `len`
  - the symbol constants `SYM_A`..`SYM_E`
  - `ESC_DIGIT` = 2'b11
  - the FSM state enum `enc_state_t`
- Sub-module `huffman_codebook`: purely combinational `sym_in` → {hit, `code_entry_t`}. It carries the escape mux under the macro. The encoder contains only the FSM and the serializer.

## Test plan
- After reset, send 'A' (0x41) with `ready_out`=1 → digits 00,00 on cycles N+1 and N+2; `last_out`=1 only on N+2.
- Send 'C' then 'D' back-to-back, `sym_valid` held high → 00,10,00,01,00 with no gap; `sym_ready`=1 on the cycle of C's last digit.
- Send 'E' with `ready_out` low for 3 cycles after `valid_out` rises → `bit_out`=10 held stable throughout; then 00 follows.
- Send 0x5A, macro undefined → `err_out` high one cycle, `valid_out` stays 0. Macro defined → digits 11,01,01,10,10.
- Drive `reset`=0 mid-code after 'C' has emitted one digit → next cycle all outputs are 0; a following 'B' emits 00,01 correctly.
- Random mapped symbols with random `ready_out` → concatenated digits match a golden model, and the downstream decoder recovers the identical symbol sequence.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman encoder slice.
// Contents:
//   CODE_DIGITS / CODE_W / LEN_W : codebook entry geometry (longest code is
//                                  the 5-digit escape form)
//   code_entry_t                 : MSB-aligned code bits plus digit count
//   SYM_A..SYM_E                 : mapped symbol values
//   ESC_DIGIT                    : leading digit reserved for escape codes
//   enc_state_t                  : encoder FSM states
package huffman_pkg;

    localparam int unsigned CODE_DIGITS = 5;
    localparam int unsigned CODE_W      = 2 * CODE_DIGITS;
    localparam int unsigned LEN_W       = $clog2(CODE_DIGITS + 1);

    typedef struct packed {
        logic [CODE_W-1:0] bits;
        logic [LEN_W-1:0]  len;
    } code_entry_t;

    localparam logic [7:0] SYM_A = 8'h41;
    localparam logic [7:0] SYM_B = 8'h42;
    localparam logic [7:0] SYM_C = 8'h43;
    localparam logic [7:0] SYM_D = 8'h44;
    localparam logic [7:0] SYM_E = 8'h45;

    localparam logic [1:0] ESC_DIGIT = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } enc_state_t;

endpackage

// File: rtl/huffman_codebook.sv
// Combinational symbol-to-code lookup.
// Ports:
//   sym_in : 8-bit symbol
//   hit    : symbol has a code (always 1 when escape encoding is enabled)
//   entry  : MSB-aligned code digits and digit count
// Build option HUFFMAN_ENC_ESCAPE_EN: unmapped symbols become the 5-digit
// escape code 11 followed by the raw symbol, MSB-first.
module huffman_codebook
    import huffman_pkg::*;
(
    input  logic [7:0]  sym_in,
    output logic        hit,
    output code_entry_t entry
);

    always_comb begin
        hit   = 1'b1;
        entry = '0;
        case (sym_in)
            SYM_A: begin
                entry.bits = {2'b00, 2'b00, 6'b0};
                entry.len  = LEN_W'(2);
            end
            SYM_B: begin
                entry.bits = {2'b00, 2'b01, 6'b0};
                entry.len  = LEN_W'(2);
            end
            SYM_C: begin
                entry.bits = {2'b00, 2'b10, 2'b00, 4'b0};
                entry.len  = LEN_W'(3);
            end
            SYM_D: begin
                entry.bits = {2'b01, 2'b00, 6'b0};
                entry.len  = LEN_W'(2);
            end
            SYM_E: begin
                entry.bits = {2'b10, 2'b00, 6'b0};
                entry.len  = LEN_W'(2);
            end
            default: begin
`ifdef HUFFMAN_ENC_ESCAPE_EN
                entry.bits = {ESC_DIGIT, sym_in};
                entry.len  = LEN_W'(5);
`else
                hit = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/huffman_encoder.sv
// Huffman encoder: accepts 8-bit symbols (valid/ready) and serializes their
// prefix-free codes MSB-first as 2-bit digits with a last-digit marker.
// Ports:
//   clk, reset       : clock; synchronous active-low reset
//   sym_in/sym_valid : input symbol and its valid
//   sym_ready        : symbol accepted this cycle (combinational)
//   bit_out          : current digit
//   valid_out        : bit_out valid
//   ready_out        : downstream accepts bit_out
//   last_out         : current digit ends its code
//   err_out          : one-cycle pulse after an unmapped symbol is rejected
// Build option HUFFMAN_ENC_ESCAPE_EN: unmapped symbols are escape-encoded by
// the codebook, so the lookup always hits and err_out never pulses.
module huffman_encoder
    import huffman_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sym_in,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic [1:0] bit_out,
    output logic       valid_out,
    input  logic       ready_out,
    output logic       last_out,
    output logic       err_out
);

    localparam int unsigned SW    = 2 * MAX_DIGITS;
    localparam int unsigned CW    = $clog2(MAX_DIGITS + 1);
    localparam int unsigned NCOPY = (SW < CODE_W) ? SW : CODE_W;

    enc_state_t     state, state_n;
    logic [SW-1:0]  sreg, sreg_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           err_n;
    logic           armed;
    logic           hit;
    code_entry_t    entry;
    logic [SW-1:0]  load_bits;
    logic           sym_fire;
    logic           dig_fire;

    huffman_codebook u_codebook (
        .sym_in (sym_in),
        .hit    (hit),
        .entry  (entry)
    );

    // MSB-align the codebook entry into the shift register regardless of
    // which of the two is wider.
    always_comb begin
        load_bits = '0;
        for (int unsigned i = 0; i < NCOPY; i++) begin
            load_bits[SW-1-i] = entry.bits[CODE_W-1-i];
        end
    end

    assign valid_out = (state == ST_SHIFT);
    assign bit_out   = sreg[SW-1 -: 2];
    assign last_out  = (state == ST_SHIFT) && (cnt == CW'(1));
    // armed holds sym_ready low for the cycle right after a reset edge.
    assign sym_ready = (state == ST_IDLE) ? armed : (last_out && ready_out);
    assign sym_fire  = sym_valid && sym_ready;
    assign dig_fire  = valid_out && ready_out;

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        err_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sym_fire) begin
                    if (hit) begin
                        sreg_n  = load_bits;
                        cnt_n   = CW'(entry.len);
                        state_n = ST_SHIFT;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (dig_fire) begin
                    if (cnt == CW'(1)) begin
                        // Last digit leaving: either reload directly from a
                        // back-to-back symbol or fall back to idle.
                        if (sym_fire && hit) begin
                            sreg_n = load_bits;
                            cnt_n  = CW'(entry.len);
                        end else begin
                            err_n   = sym_fire;
                            sreg_n  = '0;
                            cnt_n   = '0;
                            state_n = ST_IDLE;
                        end
                    end else begin
                        sreg_n = sreg << 2;
                        cnt_n  = cnt - CW'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            sreg    <= '0;
            cnt     <= '0;
            err_out <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_n;
            sreg    <= sreg_n;
            cnt     <= cnt_n;
            err_out <= err_n;
            armed   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed self-checking bench for huffman_encoder.
module tb_huffman_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] bit_out;
    logic       valid_out;
    logic       ready_out;
    logic       last_out;
    logic       err_out;

    int n_assert = 0;
    int n_fail   = 0;

    huffman_encoder #(.MAX_DIGITS(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .bit_out   (bit_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .last_out  (last_out),
        .err_out   (err_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // digit / valid / last in one go
    task automatic chk_dig(input string tag, input logic [1:0] d, input logic l);
        chk({tag, "_valid"}, {7'b0, valid_out}, 8'd1);
        chk({tag, "_bit"},   {6'b0, bit_out},   {6'b0, d});
        chk({tag, "_last"},  {7'b0, last_out},  {7'b0, l});
    endtask

    function automatic void golden(input logic [7:0] s, output logic [5:0] c, output int n);
        case (s)
            8'h41: begin c = 6'b000000; n = 2; end
            8'h42: begin c = 6'b000001; n = 2; end
            8'h43: begin c = 6'b001000; n = 3; end
            8'h44: begin c = 6'b000100; n = 2; end
            8'h45: begin c = 6'b001000; n = 2; end
            default: begin c = 6'b0; n = 0; end
        endcase
    endfunction

    function automatic logic [7:0] decode(input logic [5:0] acc, input int n);
        if (n == 2) begin
            case (acc[3:0])
                4'b0000: return 8'h41;
                4'b0001: return 8'h42;
                4'b0100: return 8'h44;
                4'b1000: return 8'h45;
                default: return 8'hFF;
            endcase
        end
        if (n == 3 && acc == 6'b001000) return 8'h43;
        return 8'hFF;
    endfunction

    logic [7:0] seq [10] = '{8'h42, 8'h45, 8'h41, 8'h43, 8'h44,
                             8'h44, 8'h41, 8'h45, 8'h43, 8'h42};
    logic [1:0] exp_d[$];
    logic       exp_l[$];
    logic [1:0] got_d[$];
    logic       got_l[$];
    logic [1:0] esc_d [5] = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b10};

    initial begin
        logic [5:0] c;
        logic [5:0] acc;
        int         n;
        int         idx;
        int         cyc;
        int         k;

        // ---- reset ----
        reset = 1'b0; sym_valid = 1'b0; sym_in = 8'h00; ready_out = 1'b1;
        tick;
        tick;
        chk("rst_sym_ready", {7'b0, sym_ready}, 8'd0);
        chk("rst_valid",     {7'b0, valid_out}, 8'd0);
        chk("rst_bit",       {6'b0, bit_out},   8'd0);
        chk("rst_last",      {7'b0, last_out},  8'd0);
        chk("rst_err",       {7'b0, err_out},   8'd0);
        reset = 1'b1;
        tick;
        chk("post_rst_ready", {7'b0, sym_ready}, 8'd1);
        chk("post_rst_valid", {7'b0, valid_out}, 8'd0);

        // ---- 'A' ----
        sym_in = 8'h41; sym_valid = 1'b1;
        tick;
        sym_valid = 1'b0;
        chk_dig("A0", 2'b00, 1'b0);
        tick;
        chk_dig("A1", 2'b00, 1'b1);
        tick;
        chk("A_idle", {7'b0, valid_out}, 8'd0);

        // ---- 'C' then 'D' back-to-back ----
        sym_in = 8'h43; sym_valid = 1'b1;
        tick;
        sym_in = 8'h44;
        chk_dig("C0", 2'b00, 1'b0);
        chk("C0_ready", {7'b0, sym_ready}, 8'd0);
        tick;
        chk_dig("C1", 2'b10, 1'b0);
        tick;
        chk_dig("C2", 2'b00, 1'b1);
        chk("C2_ready", {7'b0, sym_ready}, 8'd1);
        tick;
        sym_valid = 1'b0;
        chk_dig("D0", 2'b01, 1'b0);
        tick;
        chk_dig("D1", 2'b00, 1'b1);
        tick;
        chk("D_idle", {7'b0, valid_out}, 8'd0);

        // ---- 'E' with downstream stall ----
        sym_in = 8'h45; sym_valid = 1'b1; ready_out = 1'b0;
        tick;
        sym_valid = 1'b0;
        chk_dig("E_stall0", 2'b10, 1'b0);
        tick;
        chk_dig("E_stall1", 2'b10, 1'b0);
        tick;
        chk_dig("E_stall2", 2'b10, 1'b0);
        chk("E_stall_ready", {7'b0, sym_ready}, 8'd0);
        ready_out = 1'b1;
        tick;
        chk_dig("E1", 2'b00, 1'b1);
        tick;
        chk("E_idle", {7'b0, valid_out}, 8'd0);

        // ---- unmapped 0x5A ----
        sym_in = 8'h5A; sym_valid = 1'b1;
        tick;
        sym_valid = 1'b0;
`ifdef HUFFMAN_ENC_ESCAPE_EN
        for (int i = 0; i < 5; i++) begin
            chk("esc_err", {7'b0, err_out}, 8'd0);
            chk_dig("esc", esc_d[i], (i == 4));
            tick;
        end
        chk("esc_idle", {7'b0, valid_out}, 8'd0);
`else
        chk("unmap_err",   {7'b0, err_out},   8'd1);
        chk("unmap_valid", {7'b0, valid_out}, 8'd0);
        tick;
        chk("unmap_err_off", {7'b0, err_out},   8'd0);
        chk("unmap_valid2",  {7'b0, valid_out}, 8'd0);
`endif

        // ---- reset mid-code ----
        sym_in = 8'h43; sym_valid = 1'b1;
        tick;
        sym_valid = 1'b0;
        chk_dig("Cr0", 2'b00, 1'b0);
        tick;
        chk_dig("Cr1", 2'b10, 1'b0);
        reset = 1'b0;
        tick;
        chk("mid_rst_ready", {7'b0, sym_ready}, 8'd0);
        chk("mid_rst_valid", {7'b0, valid_out}, 8'd0);
        chk("mid_rst_bit",   {6'b0, bit_out},   8'd0);
        chk("mid_rst_last",  {7'b0, last_out},  8'd0);
        chk("mid_rst_err",   {7'b0, err_out},   8'd0);
        reset = 1'b1;
        tick;
        chk("mid_rst_rearm", {7'b0, sym_ready}, 8'd1);
        sym_in = 8'h42; sym_valid = 1'b1;
        tick;
        sym_valid = 1'b0;
        chk_dig("B0", 2'b00, 1'b0);
        tick;
        chk_dig("B1", 2'b01, 1'b1);
        tick;
        chk("B_idle", {7'b0, valid_out}, 8'd0);

        // ---- stream with irregular backpressure ----
        for (int i = 0; i < 10; i++) begin
            golden(seq[i], c, n);
            for (int j = 0; j < n; j++) begin
                exp_d.push_back(2'(c >> (2 * (n - 1 - j))));
                exp_l.push_back(j == n - 1);
            end
        end
        idx = 0;
        cyc = 0;
        while ((idx < 10 || valid_out) && cyc < 300) begin
            ready_out = ((cyc % 4) != 1) && ((cyc % 7) != 3);
            if (idx < 10) begin
                sym_valid = 1'b1;
                sym_in    = seq[idx];
            end else begin
                sym_valid = 1'b0;
            end
            #1;
            if (valid_out && ready_out) begin
                got_d.push_back(bit_out);
                got_l.push_back(last_out);
            end
            if (sym_valid && sym_ready) idx++;
            cyc++;
            tick;
        end
        sym_valid = 1'b0;
        ready_out = 1'b1;
        chk("stream_done", {7'b0, (idx == 10 && !valid_out)}, 8'd1);
        chk("stream_len", 8'(got_d.size()), 8'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk($sformatf("stream_d%0d", i), {6'b0, got_d[i]}, {6'b0, exp_d[i]});
            chk($sformatf("stream_l%0d", i), {7'b0, got_l[i]}, {7'b0, exp_l[i]});
        end
        acc = '0; n = 0; k = 0;
        for (int i = 0; i < got_d.size(); i++) begin
            acc = {acc[3:0], got_d[i]};
            n++;
            if (got_l[i]) begin
                if (k < 10) chk($sformatf("decode%0d", k), decode(acc, n), seq[k]);
                k++;
                acc = '0;
                n = 0;
            end
        end
        chk("decode_count", 8'(k), 8'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
